// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind the UART receiver: SYNC, ADDR, LEN, payload, CHK.
// The payload is buffered and only written to the register bus after the checksum passes.
`timescale 1ns/1ps

module uart_cmd_ctrl #(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 24000,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_WRITE
  } state_t;

  localparam int          IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  state_t      state;
  state_t      state_next;
  logic [7:0]  addr_q;
  logic [7:0]  len_q;
  logic [7:0]  sum_q;
  logic [7:0]  idx_q;
  logic [23:0] tmo_cnt;
  logic [7:0]  payload_buf [MAX_LEN];

  logic        accept;
  logic        wr_fire;
  logic        timed;
  logic        tmo_hit;
  logic        last_idx;
  logic        abort;
  logic        commit;
  logic [1:0]  abort_code;

  assign accept   = rx_data_valid && rx_data_ready;
  assign wr_fire  = wr_valid && wr_ready;
  assign timed    = state inside {S_ADDR, S_LEN, S_DATA, S_CHK};
  // An accepted byte always beats an expiring timeout in the same cycle.
  assign tmo_hit  = timed && !accept && (tmo_cnt == TMO_LAST);
  assign last_idx = (idx_q == len_q - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    abort      = 1'b0;
    abort_code = 2'd0;
    commit     = 1'b0;
    if (tmo_hit) begin
      abort      = 1'b1;
      abort_code = 2'd3;
      state_next = S_SYNC;
    end else begin
      case (state)
        S_SYNC:  if (accept && rx_data == SYNC_BYTE) state_next = S_ADDR;
        S_ADDR:  if (accept) state_next = S_LEN;
        S_LEN: begin
          if (accept) begin
            if (rx_data > MAX_LEN_B) begin
              abort      = 1'b1;
              abort_code = 2'd1;
              state_next = S_SYNC;
            end else if (rx_data == 8'd0) begin
              state_next = S_CHK;
            end else begin
              state_next = S_DATA;
            end
          end
        end
        S_DATA:  if (accept && last_idx) state_next = S_CHK;
        S_CHK: begin
          if (accept) begin
            if (rx_data != sum_q) begin
              abort      = 1'b1;
              abort_code = 2'd2;
              state_next = S_SYNC;
            end else if (len_q == 8'd0) begin
              commit     = 1'b1;
              state_next = S_SYNC;
            end else begin
              state_next = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (wr_fire && last_idx) begin
            commit     = 1'b1;
            state_next = S_SYNC;
          end
        end
        default: state_next = S_SYNC;
      endcase
    end
  end

  always_comb begin
    rx_data_ready = (state != S_WRITE);
    wr_valid      = 1'b0;
    wr_addr       = 8'd0;
    wr_data       = 8'd0;
    if (state == S_WRITE) begin
      wr_valid = 1'b1;
      wr_addr  = addr_q + idx_q;
      wr_data  = payload_buf[idx_q[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= 8'd0;
      len_q      <= 8'd0;
      sum_q      <= 8'd0;
      idx_q      <= 8'd0;
      tmo_cnt    <= 24'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      frame_done <= commit;
      frame_err  <= abort;
      if (abort) err_code <= abort_code;

      // The idle counter restarts on every byte and on every state change.
      if (timed && !accept && state_next == state) tmo_cnt <= tmo_cnt + 24'd1;
      else                                         tmo_cnt <= 24'd0;

      case (state)
        S_ADDR: begin
          if (accept) begin
            addr_q <= rx_data;
            sum_q  <= rx_data;
          end
        end
        S_LEN: begin
          if (accept && rx_data <= MAX_LEN_B) begin
            len_q <= rx_data;
            sum_q <= sum_q + rx_data;
            idx_q <= 8'd0;
          end
        end
        S_DATA: begin
          if (accept) begin
            sum_q <= sum_q + rx_data;
            idx_q <= idx_q + 8'd1;
          end
        end
        S_CHK:   if (accept) idx_q <= 8'd0;
        S_WRITE: if (wr_fire) idx_q <= idx_q + 8'd1;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset; only entries below LEN are ever read back.
  always_ff @(posedge clk) begin
    if (state == S_DATA && accept) payload_buf[idx_q[IDX_W-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a frame-level reference model predicts
// bus writes, completions and aborts; a monitor compares them as they appear.
`timescale 1ns/1ps

module tb_uart_cmd_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 64;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;

  uart_cmd_ctrl #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CLKS(TMO),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_NONE, EV_WR, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] a;
    logic [7:0] d;
    logic [1:0] code;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] frame_q[$];
  int         wr_cycles[$];
  int         tests = 0;
  int         failed = 0;
  int         cyc = 0;
  int         last_acc = 0;
  int         stall_n = 0;
  bit         rand_stall = 0;
  logic [1:0] held_code = 2'd0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void pushEv(input ev_kind_t k, input logic [7:0] a, input logic [7:0] d, input logic [1:0] c);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    e.code = c;
    exp_q.push_back(e);
  endfunction

  function automatic ev_t popExpect();
    ev_t e;
    e.kind = EV_NONE;
    e.a    = 8'd0;
    e.d    = 8'd0;
    e.code = 2'd0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Reference model: collects the bytes of the current frame and judges the
  // frame as a whole once its length byte or its final byte is known.
  function automatic void modelByte(input logic [7:0] b, input int gap);
    logic [7:0] sum;
    int         len;
    if (frame_q.size() > 0 && gap >= TMO) begin
      pushEv(EV_ERR, 8'd0, 8'd0, 2'd3);
      frame_q.delete();
    end
    if (frame_q.size() == 0) begin
      if (b == SYNC) frame_q.push_back(b);
      return;
    end
    frame_q.push_back(b);
    if (frame_q.size() == 3) begin
      if (int'(b) > MAX_LEN) begin
        pushEv(EV_ERR, 8'd0, 8'd0, 2'd1);
        frame_q.delete();
      end
      return;
    end
    len = int'(frame_q[2]);
    if (frame_q.size() == 4 + len) begin
      sum = 8'd0;
      for (int i = 1; i < frame_q.size() - 1; i++) sum += frame_q[i];
      if (b == sum) begin
        for (int i = 0; i < len; i++) pushEv(EV_WR, frame_q[1] + 8'(i), frame_q[3+i], 2'd0);
        pushEv(EV_DONE, 8'd0, 8'd0, 2'd0);
      end else begin
        pushEv(EV_ERR, 8'd0, 8'd0, 2'd2);
      end
      frame_q.delete();
    end
  endfunction

  function automatic void modelIdle(input int n);
    if (frame_q.size() > 0 && n >= TMO) begin
      pushEv(EV_ERR, 8'd0, 8'd0, 2'd3);
      frame_q.delete();
    end
  endfunction

  // Waits `gap` idle cycles after the previous acceptance, then offers the byte.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit acc;
    int waitc;
    modelByte(b, gap);
    repeat (gap) begin @(posedge clk); #1; end
    rx_data       = b;
    rx_data_valid = 1'b1;
    waitc         = 0;
    forever begin
      @(negedge clk);
      acc = rx_data_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waitc++;
      if (waitc > 2000) begin
        checkOutput("rx_accept_bound", 32'(waitc), 32'd0);
        break;
      end
    end
    last_acc      = cyc;
    rx_data_valid = 1'b0;
  endtask

  task automatic sendBytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) applyStimulus(bytes[i], 0);
  endtask

  task automatic idleCycles(input int n);
    modelIdle(n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rx_ready"},   32'(rx_data_ready), 32'd1);
    checkOutput({tag, "_wr_valid"},   32'(wr_valid),      32'd0);
    checkOutput({tag, "_wr_addr"},    32'(wr_addr),       32'd0);
    checkOutput({tag, "_wr_data"},    32'(wr_data),       32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done),    32'd0);
    checkOutput({tag, "_frame_err"},  32'(frame_err),     32'd0);
    checkOutput({tag, "_err_code"},   32'(err_code),      32'd0);
  endtask

  function automatic int randGap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 0;
    if (r < 90) return $urandom_range(1, 3);
    return TMO - 2;
  endfunction

  task automatic runRandom(input int frames);
    logic [7:0] bytes[$];
    logic [7:0] addr;
    logic [7:0] sum;
    logic [7:0] b;
    int         kind;
    int         len;
    int         tpos;
    int         g;
    for (int f = 0; f < frames; f++) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) applyStimulus(8'($urandom), randGap());
      kind  = $urandom_range(0, 9);
      addr  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      len   = (kind == 0) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
      bytes = '{SYNC, addr, 8'(len)};
      if (kind != 0) begin
        sum = addr + 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          bytes.push_back(b);
          sum += b;
        end
        if (kind == 1) sum ^= 8'($urandom_range(1, 255));
        bytes.push_back(sum);
      end
      tpos = $urandom_range(1, bytes.size() - 1);
      for (int i = 0; i < bytes.size(); i++) begin
        g = randGap();
        if (kind == 2 && i == tpos) g = TMO + $urandom_range(0, 3);
        applyStimulus(bytes[i], g);
      end
    end
  endtask

  // Bus-side ready driver: holds wr_ready low for stall_n cycles before each write.
  initial begin
    int waited;
    bit hs;
    waited   = 0;
    wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (hs || !rst_n) begin
        waited = 0;
        if (rand_stall) stall_n = $urandom_range(0, 3);
      end
      if (wr_valid && waited < stall_n) begin
        wr_ready = 1'b0;
        waited++;
      end else begin
        wr_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write or a pulse.
  initial begin
    bit         prev_stall;
    logic [7:0] pa;
    logic [7:0] pd;
    ev_t        e;
    prev_stall = 1'b0;
    pa         = 8'd0;
    pd         = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        checkOutput("stall_wr_valid", 32'(wr_valid), 32'd1);
        checkOutput("stall_wr_addr",  32'(wr_addr),  32'(pa));
        checkOutput("stall_wr_data",  32'(wr_data),  32'(pd));
      end
      checkOutput("rx_ready_vs_write", 32'(rx_data_ready), 32'(!wr_valid));
      if (wr_valid && wr_ready) begin
        e = popExpect();
        checkOutput("wr_event", 32'(EV_WR), 32'(e.kind));
        if (e.kind == EV_WR) begin
          checkOutput("wr_addr", 32'(wr_addr), 32'(e.a));
          checkOutput("wr_data", 32'(wr_data), 32'(e.d));
        end
        wr_cycles.push_back(cyc + 1);
      end
      if (frame_done) begin
        e = popExpect();
        checkOutput("done_event", 32'(EV_DONE), 32'(e.kind));
      end
      if (frame_err) begin
        e = popExpect();
        checkOutput("err_event", 32'(EV_ERR), 32'(e.kind));
        if (e.kind == EV_ERR) begin
          checkOutput("err_code", 32'(err_code), 32'(e.code));
          held_code = e.code;
        end
      end
      checkOutput("err_code_hold", 32'(err_code), 32'(held_code));
      prev_stall = wr_valid && !wr_ready;
      pa         = wr_addr;
      pd         = wr_data;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    rx_data       = 8'd0;
    rx_data_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkResetOutputs("after_reset");

    // Good frame with wr_ready high: three writes on consecutive cycles.
    wr_cycles.delete();
    sendBytes('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79});
    idleCycles(10);
    checkOutput("good_wr_count", 32'(wr_cycles.size()), 32'd3);
    if (wr_cycles.size() >= 3) begin
      checkOutput("good_first_wr_cycle", 32'(wr_cycles[0]), 32'(last_acc + 1));
      checkOutput("good_wr_b2b_1", 32'(wr_cycles[1]), 32'(wr_cycles[0] + 1));
      checkOutput("good_wr_b2b_2", 32'(wr_cycles[2]), 32'(wr_cycles[1] + 1));
    end

    // Bad checksum, then a good frame still commits.
    sendBytes('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h78});
    sendBytes('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79});
    idleCycles(10);

    // Garbage, length overflow, then bytes discarded until the next sync.
    sendBytes('{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h14, 8'h55, 8'h66});
    sendBytes('{8'hA5, 8'h30, 8'h01, 8'h07, 8'h38});
    idleCycles(10);

    // Silence of TIMEOUT_CLKS after ADDR aborts; gaps of TIMEOUT_CLKS-2 do not.
    sendBytes('{8'hA5, 8'h10});
    idleCycles(TMO);
    idleCycles(4);
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h10, TMO - 2);
    applyStimulus(8'h01, TMO - 2);
    applyStimulus(8'h5A, TMO - 2);
    applyStimulus(8'h6B, TMO - 2);
    idleCycles(10);

    // Address wrap with five stall cycles before each write.
    stall_n = 5;
    sendBytes('{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h66});
    idleCycles(TMO + 20);
    stall_n = 0;

    // Zero-length frame.
    sendBytes('{8'hA5, 8'h40, 8'h00, 8'h40});
    idleCycles(10);
    drain();

    rand_stall = 1'b1;
    runRandom(40);
    idleCycles(TMO + 2);
    drain();
    rand_stall = 1'b0;

    // Reset in the middle of a stalled write drops the frame without a pulse.
    stall_n = 1000;
    sendBytes('{8'hA5, 8'h40, 8'h02, 8'h01, 8'h02, 8'h45});
    repeat (5) @(posedge clk);
    #1;
    checkOutput("pre_reset_wr_valid", 32'(wr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid_write_reset");
    exp_q.delete();
    frame_q.delete();
    held_code = 2'd0;
    stall_n   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idleCycles(20);
    sendBytes('{8'hA5, 8'h80, 8'h01, 8'h3C, 8'hBD});
    idleCycles(10);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
